// File: rtl/axis_pack_8to24.sv
// axis_pack_8to24: packs three 8-bit AXI4-Stream beats into one 24-bit beat.
// The first accepted byte lands in [7:0]. A TLAST arriving before the third
// byte closes the word early: the unfilled lanes are set to PAD_BYTE and
// pad_pulse marks that word.
// Optional feature macro: AXIS_PACK_TKEEP_EN adds the m_axis_tkeep output
// and its register.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. The output side holds tdata/tlast/tkeep stable while
// valid is high and ready is low. The input side is ready whenever the
// output register is empty or is being drained in the same cycle, so a
// stalled sink back-pressures the source and no byte is ever dropped.
module axis_pack_8to24 #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef AXIS_PACK_TKEEP_EN
    output logic [2:0]  m_axis_tkeep,
`endif
    output logic        pad_pulse
);

    // Accumulator for the first two bytes of a word plus the lane counter.
    logic [7:0]  acc0_q, acc0_d;
    logic [7:0]  acc1_q, acc1_d;
    logic [1:0]  cnt_q, cnt_d;

    // Registered output stage.
    logic [23:0] data_q, data_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic        pad_q, pad_d;
`ifdef AXIS_PACK_TKEEP_EN
    logic [2:0]  keep_q, keep_d;
`endif

    logic        accept;

    // Ready only looks at the output register, never at the incoming data.
    assign s_axis_tready = ~valid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Next-state: accumulate bytes, close a word on the third byte or on TLAST.
    always_comb begin
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        pad_d   = 1'b0;
`ifdef AXIS_PACK_TKEEP_EN
        keep_d  = keep_q;
`endif
        // The sink takes the current word; a load below overrides this.
        if (valid_q && m_axis_tready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_q == 2'd2) begin
                // Third byte completes a full word, whatever tlast says.
                data_d  = {s_axis_tdata, acc1_q, acc0_q};
                last_d  = s_axis_tlast;
                valid_d = 1'b1;
                cnt_d   = 2'd0;
`ifdef AXIS_PACK_TKEEP_EN
                keep_d  = 3'b111;
`endif
            end else if (s_axis_tlast) begin
                // Early end of frame: pad the lanes above the TLAST byte.
                if (cnt_q == 2'd0) begin
                    data_d = {PAD_BYTE, PAD_BYTE, s_axis_tdata};
`ifdef AXIS_PACK_TKEEP_EN
                    keep_d = 3'b001;
`endif
                end else begin
                    data_d = {PAD_BYTE, s_axis_tdata, acc0_q};
`ifdef AXIS_PACK_TKEEP_EN
                    keep_d = 3'b011;
`endif
                end
                last_d  = 1'b1;
                valid_d = 1'b1;
                cnt_d   = 2'd0;
                pad_d   = 1'b1;
            end else begin
                if (cnt_q == 2'd0) begin
                    acc0_d = s_axis_tdata;
                end else begin
                    acc1_d = s_axis_tdata;
                end
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // State registers; reset drops partial words and any pending output.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc0_q  <= 8'h00;
            acc1_q  <= 8'h00;
            cnt_q   <= 2'd0;
            data_q  <= 24'h0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            pad_q   <= 1'b0;
`ifdef AXIS_PACK_TKEEP_EN
            keep_q  <= 3'b000;
`endif
        end else begin
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pad_q   <= pad_d;
`ifdef AXIS_PACK_TKEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;
    assign pad_pulse     = pad_q;
`ifdef AXIS_PACK_TKEEP_EN
    assign m_axis_tkeep  = keep_q;
`endif

endmodule

// File: tb/tb_axis_pack_8to24.sv
// Bench for axis_pack_8to24. Two instances share all inputs: one with the
// default pad byte 8'h00 and one with 8'hFF, so both padding values are
// checked on every word.
module tb_axis_pack_8to24;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;

    logic        s_tready0, s_tready1;
    logic [23:0] m_tdata0, m_tdata1;
    logic        m_tvalid0, m_tvalid1;
    logic        m_tlast0, m_tlast1;
    logic        pad0, pad1;
`ifdef AXIS_PACK_TKEEP_EN
    logic [2:0]  m_tkeep0, m_tkeep1;
`endif

    axis_pack_8to24 #(.PAD_BYTE(8'h00)) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready0), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast0),
`ifdef AXIS_PACK_TKEEP_EN
        .m_axis_tkeep(m_tkeep0),
`endif
        .pad_pulse(pad0)
    );

    axis_pack_8to24 #(.PAD_BYTE(8'hFF)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast1),
`ifdef AXIS_PACK_TKEEP_EN
        .m_axis_tkeep(m_tkeep1),
`endif
        .pad_pulse(pad1)
    );

    // ---------------- clock ----------------
    initial forever #5 ap_clk = ~ap_clk;

    // ---------------- bookkeeping ----------------
    localparam int W = 52;   // {keep[2:0], last, data_ff[23:0], data_00[23:0]}
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;        // 0: sink always ready, 1: sink stalled, 2: random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- sink ready driver ----------------
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'b0;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- source driver ----------------
    // Called and returns at posedge+1; the byte is accepted on the posedge
    // just before the return.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge ap_clk);
        while (!s_tready0 && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (!s_tready0) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted within 200 cycles", d);
        end
        @(posedge ap_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_reset();
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
    endtask

    // Reference packer for randomly generated frames.
    int          rc = 0;
    logic [7:0]  ra0 = 8'h00;
    logic [7:0]  ra1 = 8'h00;

    task automatic model_push(input logic [7:0] d, input logic l);
        logic [23:0] w0, wf;
        logic [2:0]  k;
        if (rc == 2) begin
            w0 = {d, ra1, ra0}; wf = w0; k = 3'b111;
            exp_q.push_back({k, l, wf, w0});
            rc = 0;
        end else if (l) begin
            if (rc == 0) begin
                w0 = {16'h0000, d}; wf = {16'hFFFF, d}; k = 3'b001;
            end else begin
                w0 = {8'h00, d, ra0}; wf = {8'hFF, d, ra0}; k = 3'b011;
            end
            exp_q.push_back({k, 1'b1, wf, w0});
            rc = 0;
        end else begin
            if (rc == 0) ra0 = d; else ra1 = d;
            rc++;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int          mon_cnt;
        logic        pad_exp, load_exp, prev_stall;
        logic [23:0] snap_d0;
        logic        snap_l;
        logic [W-1:0] e;
        mon_cnt = 0; pad_exp = 0; load_exp = 0; prev_stall = 0;
        snap_d0 = '0; snap_l = 0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                mon_cnt = 0; pad_exp = 0; load_exp = 0; prev_stall = 0;
            end else begin
                chk("pad_pulse", {31'd0, pad0}, {31'd0, pad_exp});
                chk("pad_pulse_ff", {31'd0, pad1}, {31'd0, pad_exp});
                if (load_exp) chk("latency_valid", {31'd0, m_tvalid0}, 32'd1);
                if (prev_stall) begin
                    chk("hold_data", {8'd0, m_tdata0}, {8'd0, snap_d0});
                    chk("hold_last", {31'd0, m_tlast0}, {31'd0, snap_l});
                end
                chk("s_tready", {31'd0, s_tready0}, {31'd0, (~m_tvalid0 | m_tready)});
                if (m_tvalid0 && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %h, expected none", m_tdata0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_pad00", {8'd0, m_tdata0}, {8'd0, e[23:0]});
                        chk("word_padff", {8'd0, m_tdata1}, {8'd0, e[47:24]});
                        chk("word_last", {31'd0, m_tlast0}, {31'd0, e[48]});
`ifdef AXIS_PACK_TKEEP_EN
                        chk("word_keep", {29'd0, m_tkeep0}, {29'd0, e[51:49]});
`endif
                    end
                end
                pad_exp = 0;
                load_exp = 0;
                if (s_tvalid && s_tready0) begin
                    if (mon_cnt == 2 || s_tlast) begin
                        load_exp = 1;
                        pad_exp  = (mon_cnt != 2);
                        mon_cnt  = 0;
                    end else begin
                        mon_cnt++;
                    end
                end
                prev_stall = m_tvalid0 & ~m_tready;
                snap_d0 = m_tdata0;
                snap_l  = m_tlast0;
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic        has;
        logic [23:0] w0;
        logic [23:0] wf;
        logic        wl;
        logic [2:0]  k;
    } vec_t;

    vec_t tbl[15];

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int sent;
        int len;
        tbl[0]  = '{8'h11, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[1]  = '{8'h12, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[2]  = '{8'h13, 1'b0, 1'b1, 24'h131211, 24'h131211, 1'b0, 3'b111};
        tbl[3]  = '{8'h14, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[4]  = '{8'h15, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[5]  = '{8'h16, 1'b1, 1'b1, 24'h161514, 24'h161514, 1'b1, 3'b111};
        tbl[6]  = '{8'hA1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[7]  = '{8'hA2, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[8]  = '{8'hA3, 1'b0, 1'b1, 24'hA3A2A1, 24'hA3A2A1, 1'b0, 3'b111};
        tbl[9]  = '{8'hA4, 1'b1, 1'b1, 24'h0000A4, 24'hFFFFA4, 1'b1, 3'b001};
        tbl[10] = '{8'hB1, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[11] = '{8'hB2, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[12] = '{8'hB3, 1'b0, 1'b1, 24'hB3B2B1, 24'hB3B2B1, 1'b0, 3'b111};
        tbl[13] = '{8'hB4, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 3'b000};
        tbl[14] = '{8'hB5, 1'b1, 1'b1, 24'h00B5B4, 24'hFFB5B4, 1'b1, 3'b011};

        // Reset values.
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_tvalid", {31'd0, m_tvalid0}, 32'd0);
        chk("rst_tdata", {8'd0, m_tdata0}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast0}, 32'd0);
        chk("rst_pad", {31'd0, pad0}, 32'd0);
        chk("rst_tready", {31'd0, s_tready0}, 32'd1);
`ifdef AXIS_PACK_TKEEP_EN
        chk("rst_tkeep", {29'd0, m_tkeep0}, 32'd0);
`endif
        @(posedge ap_clk);
        #1;

        // Directed frames from the table, back-to-back with the sink ready.
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].has) exp_q.push_back({tbl[i].k, tbl[i].wl, tbl[i].wf, tbl[i].w0});
            send_byte(tbl[i].d, tbl[i].l);
        end
        idle(3);

        // One-byte frames back to back: one padded word per cycle.
        for (int i = 0; i < 4; i++) begin
            model_push(8'hD0 + 8'(i), 1'b1);
            send_byte(8'hD0 + 8'(i), 1'b1);
        end
        idle(3);

        // Sink stalled for 10 cycles while 9 bytes are offered.
        rdy_mode = 1;
        idle(1);
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    model_push(8'hC1 + 8'(i), i == 8);
                    send_byte(8'hC1 + 8'(i), i == 8);
                end
            end
            begin
                repeat (6) @(posedge ap_clk);
                @(negedge ap_clk);
                chk("stall_tready_low", {31'd0, s_tready0}, 32'd0);
                chk("stall_tvalid_high", {31'd0, m_tvalid0}, 32'd1);
                chk("stall_word", {8'd0, m_tdata0}, 32'h00C3C2C1);
                repeat (4) @(posedge ap_clk);
                #1;
                rdy_mode = 0;
            end
        join
        idle(4);

        // Reset with a word pending in the stalled output register.
        rdy_mode = 1;
        idle(1);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        idle(1);
        pulse_reset();
        @(negedge ap_clk);
        chk("rst_pending_tvalid", {31'd0, m_tvalid0}, 32'd0);
        @(posedge ap_clk);
        #1;
        rdy_mode = 0;
        idle(2);

        // Reset after two bytes of a frame, then a fresh 3-byte frame.
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        pulse_reset();
        @(negedge ap_clk);
        chk("rst_mid_tvalid", {31'd0, m_tvalid0}, 32'd0);
        @(posedge ap_clk);
        #1;
        exp_q.push_back({3'b111, 1'b1, 24'h434241, 24'h434241});
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b1);
        idle(3);

        // Random frames with ~50% source valid and ~50% sink ready.
        rdy_mode = 2;
        rc = 0;
        sent = 0;
        while (sent < 3000) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) idle(1);
                model_push(d, i == len - 1);
                send_byte(d, i == len - 1);
                sent++;
            end
        end
        rdy_mode = 0;

        // Drain.
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge ap_clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pack_8to24.md
# axis_pack_8to24

Stream upsizer for the image-filter output path. It packs three consecutive 8-bit AXI4-Stream beats into one 24-bit beat and provides full input throughput using a registered output stage. On TLAST it pads a partial group and flushes it immediately. It sits between the 8-bit filter core output and the 24-bit pixel DMA/video sink, and is the converse of the 24-to-8 input-side converter.

## Interface
Parameters:
- PAD_BYTE, 8'h00, value written into unfilled byte lanes of a word closed early by TLAST

Ports:
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of frame/line marker
- m_axis_tdata  out  24  packed word; first accepted byte in [7:0], second in [15:8], third in [23:16]
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  word contains the byte that carried s_axis_tlast
- m_axis_tkeep  out  3  per-byte-lane valid (only with AXIS_PACK_TKEEP_EN)
- pad_pulse  out  1  one-cycle pulse when a padded (partial) word is loaded into the output register

## Operation
- Accumulator: two byte registers acc0/acc1 plus lane counter cnt ∈ {0,1,2}.
- Input handshake: s_axis_tready = ~m_axis_tvalid | m_axis_tready. A byte is accepted when s_axis_tvalid & s_axis_tready. Ready never depends on s_axis_tdata or s_axis_tlast.
- On acceptance with tlast=0 and cnt<2: store the byte in lane cnt and set cnt++.
- On acceptance with cnt==2 (any tlast): load the output register with {byte, acc1, acc0}, set m_axis_tlast=tlast and cnt=0.
- On acceptance with tlast=1 and cnt<2: load the output register immediately. Lanes above cnt get PAD_BYTE. Set m_axis_tlast=1, cnt=0, pad_pulse=1.
  - cnt==0 gives {PAD,PAD,b}.
  - cnt==1 gives {PAD,b,acc0}.
- Output register: m_axis_tvalid sets on load. It clears on m_axis_tvalid & m_axis_tready when no new load occurs in the same cycle. A load and a drain in the same cycle keep m_axis_tvalid=1 and carry the new contents.
- m_axis_tdata, m_axis_tlast and m_axis_tkeep hold stable while m_axis_tvalid & ~m_axis_tready.
- No frame may lose or duplicate a byte. A stalled output blocks input and does not drop data.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tkeep=0, pad_pulse=0, cnt=0. s_axis_tready=1 in the cycle after reset.
- Reset mid-frame discards any accumulated bytes and the pending output word.
- Latency: the word is valid on m_axis the cycle after the accepting edge of its final byte (third byte or the TLAST byte).
- Throughput: 1 byte/cycle sustained when m_axis_tready=1. The output rate is 1 word per 3 cycles, or one per TLAST.
- Back-to-back one-byte frames (tlast every beat) run at 1 word/cycle when m_axis_tready=1.
- pad_pulse is high for exactly the cycle after the padding load, aligned with the first cycle of that m_axis_tvalid.

## Configuration
- AXIS_PACK_TKEEP_EN defined:
  - m_axis_tkeep port exists.
  - Full word gives 3'b111. Padded words give 3'b001 (cnt==0) or 3'b011 (cnt==1).
  - tkeep follows the same load/hold rules as tdata.
- AXIS_PACK_TKEEP_EN undefined:
  - m_axis_tkeep port and its register are absent.
  - Padding still uses PAD_BYTE, and pad_pulse is still the only partial-word indicator.

## Test plan
- Reset, then 6 bytes 0x11..0x16, tlast on 0x16, m_axis_tready=1. Expected: words 0x131211 (tlast=0) then 0x161514 (tlast=1), each 1 cycle after its third byte; pad_pulse never asserts.
- 4 bytes 0xA1..0xA4, tlast on 0xA4. Expected: 0xA3A2A1, then 0x0000A4 with tlast=1, pad_pulse=1, tkeep=3'b001 (with TKEEP_EN).
- 5 bytes, tlast on the 5th, PAD_BYTE=8'hFF. Expected: second word {FF,b5,b4}, tkeep=3'b011.
- m_axis_tready held 0 for 10 cycles while input streams 9 bytes. Expected: s_axis_tready drops once a word is pending, output data is stable throughout, and on release all 3 words arrive in order with no loss.
- Random tvalid/tready (50%) over 3000 bytes across random-length frames. Expected: the scoreboard byte stream and TLAST positions match exactly.
- ap_rst asserted after 2 bytes of a frame. Expected: next cycle m_axis_tvalid=0; a subsequent 3-byte frame produces exactly one word containing only the new bytes.
